izh_neuron_sequencer: RTL

- Time-multiplexes one combinational Izhikevich integrator across N_NEURON neurons.
- Holds per-neuron v/w state registers, sweeps all neurons once per tick and drives the integrator inputs.
- Writes integrator results back to state and buffers spike events in a small FIFO for downstream consumers (synapse/routing logic).

---
 rtl/izh_pkg.sv | 26 ++
 rtl/izh_spike_fifo.sv | 51 +++++
 rtl/izh_neuron_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich neuron sequencer.
package izh_pkg;

   localparam int DEF_V_WIDTH  = 20;
   localparam int DEF_FR_WIDTH = 11;

   function automatic int fx(input int k, input int fr);
      return k * (2 ** fr);
   endfunction

   localparam int V_RESET = fx(-65, DEF_FR_WIDTH);
   localparam int W_RESET = fx(-13, DEF_FR_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic signed [DEF_V_WIDTH-1:0] v;
      logic signed [DEF_V_WIDTH-1:0] w;
   } neuron_state_t;

endpackage

// File: rtl/izh_spike_fifo.sv
// Spike index FIFO; a push into a full FIFO is accepted only alongside a pop.
module izh_spike_fifo #(
   parameter int SPK_DEPTH = 4,
   parameter int IDX_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [IDX_WIDTH-1:0] push_data,
   output logic                 full,
   input  logic                 pop,
   output logic                 valid,
   output logic [IDX_WIDTH-1:0] head
);

   localparam int AW = $clog2(SPK_DEPTH);

   logic [IDX_WIDTH-1:0] mem_q [SPK_DEPTH];
   logic [AW-1:0]        wr_q;
   logic [AW-1:0]        rd_q;
   logic [AW:0]          cnt_q;
   logic                 do_pop;
   logic                 do_push;

   assign full    = (cnt_q == (AW+1)'(SPK_DEPTH));
   assign valid   = (cnt_q != '0);
   assign head    = valid ? mem_q[rd_q] : '0;
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < SPK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/izh_neuron_sequencer.sv
// Sweeps N_NEURON neuron states through one shared Izhikevich integrator.
// Define IZH_STATE_PROBE_EN to add the probe_idx/probe_v/probe_w state probe.
module izh_neuron_sequencer
   import izh_pkg::*;
#(
   parameter int V_WIDTH   = DEF_V_WIDTH,
   parameter int FR_WIDTH  = DEF_FR_WIDTH,
   parameter int N_NEURON  = 16,
   parameter int IDX_WIDTH = 4,
   parameter int SPK_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_WIDTH-1:0] cur_idx,
   input  logic [V_WIDTH-1:0]   cur_I,
   output logic [V_WIDTH-1:0]   int_v_old,
   output logic [V_WIDTH-1:0]   int_w_old,
   output logic [V_WIDTH-1:0]   int_I,
   input  logic [V_WIDTH-1:0]   int_v_new,
   input  logic [V_WIDTH-1:0]   int_w_new,
   input  logic                 int_fire,
`ifdef IZH_STATE_PROBE_EN
   input  logic [IDX_WIDTH-1:0] probe_idx,
   output logic [V_WIDTH-1:0]   probe_v,
   output logic [V_WIDTH-1:0]   probe_w,
`endif
   output logic                 spk_valid,
   output logic [IDX_WIDTH-1:0] spk_idx,
   input  logic                 spk_ready
);

   localparam logic [V_WIDTH-1:0]   V_RST = V_WIDTH'(fx(-65, FR_WIDTH));
   localparam logic [V_WIDTH-1:0]   W_RST = V_WIDTH'(fx(-13, FR_WIDTH));
   localparam logic [IDX_WIDTH-1:0] LAST  = IDX_WIDTH'(N_NEURON - 1);

   seq_state_e           state_q;
   logic [IDX_WIDTH-1:0] idx_q;
   logic                 busy_q;
   logic                 done_q;
   logic [V_WIDTH-1:0]   v_old_q;
   logic [V_WIDTH-1:0]   w_old_q;
   logic [V_WIDTH-1:0]   i_q;
   logic [V_WIDTH-1:0]   v_q [N_NEURON];
   logic [V_WIDTH-1:0]   w_q [N_NEURON];

   logic fifo_full;
   logic fifo_pop;
   logic blocked;
   logic push;

   assign busy      = busy_q;
   assign done      = done_q;
   assign cur_idx   = idx_q;
   assign int_v_old = v_old_q;
   assign int_w_old = w_old_q;
   assign int_I     = i_q;

   // A spike that cannot be buffered holds the whole write back.
   assign fifo_pop = spk_valid & spk_ready;
   assign blocked  = int_fire & fifo_full & ~fifo_pop;
   assign push     = (state_q == WRITE) & int_fire & ~blocked;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         v_old_q <= '0;
         w_old_q <= '0;
         i_q     <= '0;
         for (int n = 0; n < N_NEURON; n++) begin
            v_q[n] <= V_RST;
            w_q[n] <= W_RST;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q <= READ;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            READ: begin
               v_old_q <= v_q[idx_q];
               w_old_q <= w_q[idx_q];
               i_q     <= cur_I;
               state_q <= WRITE;
            end
            WRITE: begin
               if (!blocked) begin
                  v_q[idx_q] <= int_v_new;
                  w_q[idx_q] <= int_w_new;
                  if (idx_q == LAST) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= READ;
                  end
               end
            end
            DONE: begin
               idx_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IZH_STATE_PROBE_EN
   assign probe_v = (int'(probe_idx) < N_NEURON) ? v_q[probe_idx] : '0;
   assign probe_w = (int'(probe_idx) < N_NEURON) ? w_q[probe_idx] : '0;
`endif

   izh_spike_fifo #(
      .SPK_DEPTH (SPK_DEPTH),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (idx_q),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .valid     (spk_valid),
      .head      (spk_idx)
   );

endmodule
